// File: rtl/bitstream_period_decoder_pkg.sv
// Shared definitions for the square-wave bitstream link.
// The generator and the decoder both use the expected half-period lengths.
// Contents:
//   dec_state_t        decoder FSM states
//   DEFAULT_*          default debounce depth, timeout and counter width
//   HALF_PERIOD_*      nominal low/high run lengths of the link waveform
package bitstream_period_decoder_pkg;

    typedef enum logic [1:0] {
        SEARCH   = 2'd0,
        RUN_LOW  = 2'd1,
        RUN_HIGH = 2'd2,
        LOST     = 2'd3
    } dec_state_t;

    localparam int unsigned DEFAULT_CNT_W    = 16;
    localparam int unsigned DEFAULT_DEBOUNCE = 4;
    localparam int unsigned DEFAULT_TIMEOUT  = 8192;

    localparam int unsigned HALF_PERIOD_LOW  = 2096;
    localparam int unsigned HALF_PERIOD_HIGH = 2093;

endpackage

// File: rtl/bitstream_period_decoder_hysteresis_slicer.sv
// Front end of the bitstream decoder: input register, hysteresis slicer and
// debounce filter.
// Ports:
//   clk        instrument clock, posedge
//   reset      synchronous, active-high
//   sample_in  signed ADC sample
//   thresh_hi  slicer goes 1 when the registered sample is >= thresh_hi
//   thresh_lo  slicer goes 0 when the registered sample is <= thresh_lo
//   level      debounced logic level
//   edge_stb   1-cycle strobe in the cycle level changes
module hysteresis_slicer
    import bitstream_period_decoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DEFAULT_DEBOUNCE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] sample_in,
    input  logic signed [15:0] thresh_hi,
    input  logic signed [15:0] thresh_lo,
    output logic               level,
    output logic               edge_stb
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE + 1);

    logic signed [15:0] sample_q;
    logic               slice_q;
    logic [DB_W-1:0]    db_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q <= '0;
            slice_q  <= 1'b0;
            db_cnt   <= '0;
            level    <= 1'b0;
            edge_stb <= 1'b0;
        end else begin
            sample_q <= sample_in;

            // High test first so an inverted threshold pair still resolves to 1.
            if (sample_q >= thresh_hi) begin
                slice_q <= 1'b1;
            end else if (sample_q <= thresh_lo) begin
                slice_q <= 1'b0;
            end

            // Count consecutive samples that disagree with the accepted level;
            // any agreeing sample restarts the count.
            edge_stb <= 1'b0;
            if (slice_q != level) begin
                if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
                    level    <= slice_q;
                    edge_stb <= 1'b1;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/bitstream_period_decoder.sv
// Receive end of the square-wave bitstream link. Slices the ADC input into a
// debounced level, measures high and low run lengths and reports each
// complete period.
// Ports:
//   clk           instrument clock, posedge
//   reset         synchronous, active-high
//   sample_in     signed ADC sample
//   thresh_hi     signed upper slicer threshold
//   thresh_lo     signed lower slicer threshold
//   level_out     debounced logic level
//   high_len      last complete high run length (cycles)
//   low_len       last complete low run length (cycles)
//   period_valid  1-cycle strobe: high_len/low_len hold a new period
//   period_count  number of period_valid strobes since reset (wraps)
//   locked        a full period has been measured and no timeout since
//   lost          sticky timeout flag, cleared by the next accepted edge
module bitstream_period_decoder
    import bitstream_period_decoder_pkg::*;
#(
    parameter int unsigned CNT_W    = DEFAULT_CNT_W,
    parameter int unsigned DEBOUNCE = DEFAULT_DEBOUNCE,
    parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] sample_in,
    input  logic signed [15:0] thresh_hi,
    input  logic signed [15:0] thresh_lo,
    output logic               level_out,
    output logic [CNT_W-1:0]   high_len,
    output logic [CNT_W-1:0]   low_len,
    output logic               period_valid,
    output logic [15:0]        period_count,
    output logic               locked,
    output logic               lost
);

    logic             level;
    logic             edge_stb;
    dec_state_t       state;
    dec_state_t       state_nxt;
    logic [CNT_W-1:0] run_cnt;
    logic             low_valid;

    logic             timed_out;
    logic             latch_low;
    logic             latch_high;
    logic             emit;
    logic             timeout_hit;
    logic             resync;

    hysteresis_slicer #(
        .DEBOUNCE (DEBOUNCE)
    ) u_slicer (
        .clk       (clk),
        .reset     (reset),
        .sample_in (sample_in),
        .thresh_hi (thresh_hi),
        .thresh_lo (thresh_lo),
        .level     (level),
        .edge_stb  (edge_stb)
    );

    assign level_out = level;
    assign timed_out = (run_cnt >= CNT_W'(TIMEOUT));

    // Levels alternate, so an edge seen in RUN_LOW is always rising and one
    // seen in RUN_HIGH is always falling.
    always_comb begin
        state_nxt   = state;
        latch_low   = 1'b0;
        latch_high  = 1'b0;
        emit        = 1'b0;
        timeout_hit = 1'b0;
        resync      = 1'b0;
        case (state)
            SEARCH, LOST: begin
                if (edge_stb) begin
                    state_nxt = level ? RUN_HIGH : RUN_LOW;
                    resync    = 1'b1;
                end
            end
            RUN_LOW: begin
                if (edge_stb) begin
                    latch_low = 1'b1;
                    state_nxt = RUN_HIGH;
                end else if (timed_out) begin
                    timeout_hit = 1'b1;
                    state_nxt   = LOST;
                end
            end
            RUN_HIGH: begin
                if (edge_stb) begin
                    latch_high = 1'b1;
                    emit       = low_valid;
                    state_nxt  = RUN_LOW;
                end else if (timed_out) begin
                    timeout_hit = 1'b1;
                    state_nxt   = LOST;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SEARCH;
            run_cnt      <= '0;
            low_valid    <= 1'b0;
            high_len     <= '0;
            low_len      <= '0;
            period_valid <= 1'b0;
            period_count <= '0;
            locked       <= 1'b0;
            lost         <= 1'b0;
        end else begin
            state <= state_nxt;

            // The value held when the next edge arrives is the run length.
            if (edge_stb) begin
                run_cnt <= CNT_W'(1);
            end else if (run_cnt != '1) begin
                run_cnt <= run_cnt + 1'b1;
            end

            period_valid <= emit;
            if (latch_low) begin
                low_len   <= run_cnt;
                low_valid <= 1'b1;
            end
            if (latch_high) begin
                high_len <= run_cnt;
            end
            if (emit) begin
                period_count <= period_count + 1'b1;
                locked       <= 1'b1;
            end
            // After a timeout the next low run must be seen in full again
            // before a period can be reported.
            if (timeout_hit) begin
                lost      <= 1'b1;
                locked    <= 1'b0;
                low_valid <= 1'b0;
            end
            if (resync) begin
                lost <= 1'b0;
            end
        end
    end

endmodule
